// File: rtl/nand_gate_pkg.sv
// Shared definitions for the NAND gate block: the per-bit NAND expression
// and the reset value of the registered output.
package nand_gate_pkg;

  // Widest vector the reset constant covers.
  localparam int MAX_W = 64;

  // Reset value of y_q: the NAND of two zero operands, i.e. all ones.
  localparam logic [MAX_W-1:0] RST_Y = '1;

  function automatic logic nand_bit(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_gate_cell.sv
// Single-bit combinational NAND.
// It is replicated once per bit of the vector gate.
module nand_cell
  import nand_gate_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = nand_bit(a, b);

endmodule

// File: rtl/nand_gate.sv
// Bitwise NAND with a zero-latency combinational output.
// It also holds a registered copy of the result and a saturating count of cycles in which that copy changed.
module nand_gate
  import nand_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic [CNT_W-1:0] tgl_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] y_q_reg;
  logic [WIDTH-1:0] y_q_next;
  logic [CNT_W-1:0] tgl_cnt_reg;
  logic [CNT_W-1:0] tgl_cnt_next;

  // y has no path through clk, rst or en, so the block works as a bare gate.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      nand_cell u_cell (
        .a (a[gi]),
        .b (b[gi]),
        .y (y[gi])
      );
    end
  endgenerate

  // The counter advances at most once per cycle, however many bits change.
  // It stops at its maximum value and does not wrap.
  always_comb begin
    y_q_next     = y_q_reg;
    tgl_cnt_next = tgl_cnt_reg;
    if (en) begin
      y_q_next = y;
      if ((y != y_q_reg) && (tgl_cnt_reg != CNT_MAX)) begin
        tgl_cnt_next = tgl_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q_reg     <= RST_Y[WIDTH-1:0];
      tgl_cnt_reg <= '0;
    end else begin
      y_q_reg     <= y_q_next;
      tgl_cnt_reg <= tgl_cnt_next;
    end
  end

  assign y_q     = y_q_reg;
  assign tgl_cnt = tgl_cnt_reg;

endmodule

// File: tb/tb_nand_gate.sv
// Scoreboard bench for nand_gate.
// It uses a 1-bit instance with an 8-bit counter and a 4-bit instance with a 2-bit counter.
module tb_nand_gate;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;

  logic       rst1 = 1'b0, en1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [0:0] y1, y_q1;
  logic [7:0] cnt1;

  logic       rst4 = 1'b0, en4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] y4, y_q4;
  logic [1:0] cnt4;

  nand_gate #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .en(en1),
    .y(y1), .y_q(y_q1), .tgl_cnt(cnt1)
  );

  nand_gate #(.WIDTH(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .en(en4),
    .y(y4), .y_q(y_q4), .tgl_cnt(cnt4)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct {
    int         sel;
    logic [3:0] yq;
    int         cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_yq[2];
  int         m_cnt[2];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Drive one cycle on the selected instance (0: 1-bit, 1: 4-bit).
  // Check y right away, then check y_q and tgl_cnt after the next rising edge.
  task automatic step(input int sel, input logic [3:0] a, input logic [3:0] b,
                      input logic en, input logic rst, input string tag);
    logic [3:0] mask;
    logic [3:0] nv;
    int         cmax;
    exp_t       e;
    exp_t       got_e;
    mask = (sel == 1) ? 4'hF : 4'h1;
    cmax = (sel == 1) ? 3 : 255;
    nv   = ~(a & b) & mask;
    if (sel == 1) begin
      a4 = a; b4 = b; en4 = en; rst4 = rst;
    end else begin
      a1 = a[0:0]; b1 = b[0:0]; en1 = en; rst1 = rst;
    end
    if (rst) begin
      m_yq[sel]  = mask;
      m_cnt[sel] = 0;
    end else if (en) begin
      if (nv != m_yq[sel] && m_cnt[sel] < cmax) m_cnt[sel]++;
      m_yq[sel] = nv;
    end
    e.sel = sel; e.yq = m_yq[sel]; e.cnt = m_cnt[sel];
    sb_q.push_back(e);
    #1;
    chk({tag, ".y"}, (sel == 1) ? 32'(y4) : 32'(y1), 32'(nv));
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    if (got_e.sel == 1) begin
      chk({tag, ".y_q"}, 32'(y_q4), 32'(got_e.yq));
      chk({tag, ".cnt"}, 32'(cnt4), 32'(got_e.cnt));
    end else begin
      chk({tag, ".y_q"}, 32'(y_q1), 32'(got_e.yq));
      chk({tag, ".cnt"}, 32'(cnt1), 32'(got_e.cnt));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] tt_exp;
    tt_exp = 4'b0111;
    // Truth table with the clock idle: a, b are the two bits of the index i.
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      #1;
      chk($sformatf("tt%0d%0d", (i >> 1) & 1, i & 1), 32'(y1), 32'(tt_exp[i]));
    end

    clk_run = 1'b1;
    @(posedge clk);
    #1;

    // 1-bit instance: reset, latency, enable hold, no-change cycle.
    step(0, 4'h1, 4'h1, 1'b1, 1'b1, "rst1_a");
    step(0, 4'h1, 4'h1, 1'b1, 1'b1, "rst1_b");
    step(0, 4'h1, 4'h1, 1'b1, 1'b0, "lat_11");
    step(0, 4'h0, 4'h1, 1'b1, 1'b0, "lat_01");
    for (int i = 0; i < 4; i++) begin
      step(0, 4'(i & 1), 4'(i & 1), 1'b0, 1'b0, $sformatf("hold%0d", i));
    end
    step(0, 4'h0, 4'h0, 1'b1, 1'b0, "same");
    step(0, 4'h1, 4'h1, 1'b0, 1'b1, "rst_no_en");

    // 4-bit instance with a 2-bit counter: vector, saturation, mid-run reset.
    en1 = 1'b0;
    step(1, 4'hC, 4'hA, 1'b0, 1'b1, "rst4");
    step(1, 4'hC, 4'hA, 1'b1, 1'b0, "vec");
    for (int i = 0; i < 6; i++) begin
      step(1, (i % 2 == 0) ? 4'hF : 4'h0, (i % 2 == 0) ? 4'hF : 4'h0,
           1'b1, 1'b0, $sformatf("sat%0d", i));
    end
    step(1, 4'hF, 4'hF, 1'b1, 1'b1, "rst_mid");
    step(1, 4'h5, 4'hF, 1'b1, 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nand_gate.md
Name: nand_gate

Overview:
- Two-input bitwise NAND block with a combinational output `y = ~(a & b)`.
- Also provides a registered copy of the result and a saturating activity counter that counts changes of the registered output.
- Serves as the basic logic-gate primitive in the modeling-basics examples. It is usable as a pure gate when clk/rst are tied off.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q (bitwise operation per bit)
- CNT_W, 8, width of the toggle counter tgl_cnt

Ports:
- clk  input  1  clock; all registers update on the rising edge
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- en  input  1  register-update enable for y_q and tgl_cnt
- y  output  WIDTH  combinational NAND result, ~(a & b)
- y_q  output  WIDTH  registered NAND result
- tgl_cnt  output  CNT_W  number of cycles in which y_q changed value, saturating

Behaviour:
- y is purely combinational, with zero latency and no dependence on clk, rst or en.
  - Per bit: 00->1, 01->1, 10->1, 11->0.
  - y must be valid with clk held constant and rst unconnected, so the block is usable as a bare gate.
- Reset: clk and rst are one clock domain; reset is synchronous and active-high.
  - On a rising clk edge with rst=1: y_q <= all ones (the NAND of 0,0) and tgl_cnt <= 0.
  - rst has priority over en. Reset asserted mid-operation clears on the next edge regardless of other inputs.
- Registered path:
  - On a rising edge with rst=0 and en=1: y_q <= ~(a & b), one-cycle latency.
  - With en=0: y_q holds its value.
- Toggle counter:
  - On an edge with rst=0, en=1 and (~(a & b) != y_q): tgl_cnt <= tgl_cnt + 1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - Counts at most one per cycle, whatever the number of bits that changed.
  - Does not increment when en=0 or when the new value equals y_q.
- X/Z on a or b propagates through y per standard Verilog semantics; no masking is required.
- No handshake, no state machine beyond the y_q/tgl_cnt registers.

Decomposition:
- Shared package: a function implementing the bitwise NAND (so y and the y_q next-state use the same expression) and the reset constant RST_Y = all ones.
- One natural sub-module: nand_cell (single-bit combinational NAND), replicated WIDTH times via generate. The registers and counter stay in nand_gate.

Test Plan:
- Combinational truth table, WIDTH=1, clk idle, rst=0. Step (a,b) through 00, 01, 10, 11 at 1 ns intervals; y must be 1, 1, 1, 0, settled within each step.
- Reset: hold rst=1 for 2 edges with a=1, b=1, en=1 -> y_q=1, tgl_cnt=0. y stays combinational 0 throughout.
- Registered latency: rst=0, en=1, apply a=1,b=1 -> y_q becomes 0 after exactly one edge and tgl_cnt=1. Then a=0 -> y_q=1 and tgl_cnt=2 at the next edge.
- Enable hold: en=0, toggle a/b every cycle for 4 cycles -> y_q and tgl_cnt unchanged; y still follows the inputs.
- Saturation: CNT_W=2, en=1, alternate a=b=1 and a=b=0 every cycle for 6 cycles -> tgl_cnt reaches 3 and stays at 3.
- Vector width: WIDTH=4, a=4'b1100, b=4'b1010 -> y=4'b0111 and, after one edge, y_q=4'b0111. Assert rst mid-sequence -> y_q=4'b1111 and tgl_cnt=0 on the next edge.
